// File: rtl/bcd6_scan_display.sv
// ---------------------------------------------------------------------------
// bcd6_scan_display
//
// Six-digit multiplexed 7-segment display driver. A LOAD strobe captures a
// 24-bit packed BCD value into a holding register. The six digits are then
// scanned onto a shared segment bus. Each digit is selected for SCAN_DIV
// cycles. The first of those cycles is a blanked dead-time cycle that
// suppresses ghosting. Optional leading-zero blanking is available.
//
// Ports
//   CLK       system clock, rising edge
//   RST_N     asynchronous active-low reset
//   LOAD      capture strobe for BCD_IN (level sensitive, sampled every edge)
//   BCD_IN    packed BCD, digit k in bits [4k+3:4k], digit 0 least significant
//   BLANK_EN  1 = blank leading zeros (digit 0 is never blanked)
//   SEG       registered segment drive, active-high, SEG[0]=a .. SEG[6]=g
//   DIG_N     registered digit select, active-low one-hot
//
// Parameters
//   SCAN_DIV  cycles per digit including the dead-time cycle (2..65535)
// ---------------------------------------------------------------------------
module bcd6_scan_display #(
    parameter int unsigned SCAN_DIV = 1000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        LOAD,
    input  logic [23:0] BCD_IN,
    input  logic        BLANK_EN,
    output logic [6:0]  SEG,
    output logic [5:0]  DIG_N
);

    localparam logic [15:0] CNT_MAX = 16'(SCAN_DIV - 1);

    logic [23:0] hold;
    logic [15:0] cnt;
    logic [2:0]  idx;

    logic [3:0]  cur_digit;
    logic        upper_zero;
    logic [6:0]  seg_dec;
    logic [6:0]  seg_next;
    logic [5:0]  dig_next;

    // Holding register: recaptures on every edge LOAD is high.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hold <= '0;
        end else if (LOAD) begin
            hold <= BCD_IN;
        end
    end

    // Prescaler and digit index. IDX only moves when the prescaler wraps.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_MAX) begin
            cnt <= '0;
            idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

    // Digit under the scan pointer, plus "this digit and everything above it
    // is zero". Invalid codes are non-zero, so a plain compare is enough.
    // Digit 0 never reports upper_zero so a value of 0 still shows "0".
    always_comb begin
        cur_digit  = 4'd0;
        upper_zero = 1'b0;
        case (idx)
            3'd0: cur_digit = hold[3:0];
            3'd1: begin cur_digit = hold[7:4];   upper_zero = (hold[23:4]  == 20'd0); end
            3'd2: begin cur_digit = hold[11:8];  upper_zero = (hold[23:8]  == 16'd0); end
            3'd3: begin cur_digit = hold[15:12]; upper_zero = (hold[23:12] == 12'd0); end
            3'd4: begin cur_digit = hold[19:16]; upper_zero = (hold[23:16] == 8'd0);  end
            3'd5: begin cur_digit = hold[23:20]; upper_zero = (hold[23:20] == 4'd0);  end
            default: begin cur_digit = 4'd0; upper_zero = 1'b0; end
        endcase
    end

    // Segment decode, bit order g..a. Codes 10..15 show a dash.
    always_comb begin
        seg_dec = 7'b1000000;
        case (cur_digit)
            4'd0: seg_dec = 7'b0111111;
            4'd1: seg_dec = 7'b0000110;
            4'd2: seg_dec = 7'b1011011;
            4'd3: seg_dec = 7'b1001111;
            4'd4: seg_dec = 7'b1100110;
            4'd5: seg_dec = 7'b1101101;
            4'd6: seg_dec = 7'b1111101;
            4'd7: seg_dec = 7'b0000111;
            4'd8: seg_dec = 7'b1111111;
            4'd9: seg_dec = 7'b1101111;
            default: seg_dec = 7'b1000000;
        endcase
    end

    // Next output word. CNT=0 is the dead-time cycle: nothing selected.
    always_comb begin
        dig_next = 6'b111111;
        seg_next = 7'b0000000;
        if (cnt != 16'd0) begin
            dig_next = ~(6'b000001 << idx);
            seg_next = (BLANK_EN && upper_zero) ? 7'b0000000 : seg_dec;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            SEG   <= 7'b0000000;
            DIG_N <= 6'b111111;
        end else begin
            SEG   <= seg_next;
            DIG_N <= dig_next;
        end
    end

endmodule

// File: doc/bcd6_scan_display.md
# bcd6_scan_display

Six-digit multiplexed 7-segment display driver for the frequency-meter datapath. It sits directly downstream of the 6-digit BCD measurement counter. On a LOAD strobe it captures that counter's 24-bit packed BCD value into an internal holding register. It then time-multiplexes the six digits onto a shared segment bus, with optional leading-zero blanking and one dead-time cycle per digit change to suppress ghosting.

## Interface
Parameters:
- SCAN_DIV, 1000: CLK cycles each digit stays selected, including its dead-time cycle. Legal range is 2..65535.

Ports:
- CLK  input  1  system clock. Every register updates on its rising edge.
- RST_N  input  1  reset, asynchronous and active-low.
- LOAD  input  1  latch strobe. When high at a CLK edge, BCD_IN is captured.
- BCD_IN  input  24  packed BCD. Digit k occupies bits [4k+3:4k]; digit 0 is the least significant.
- BLANK_EN  input  1  1 enables leading-zero blanking.
- SEG  output  7  segment drive, active-high. SEG[0]=a through SEG[6]=g.
- DIG_N  output  6  digit select, active-low one-hot. DIG_N[k] selects digit k.

## Operation
- Holding register HOLD[23:0]:
  - Captures BCD_IN at any CLK edge where LOAD=1.
  - Otherwise holds its value.
  - LOAD may stay high for several cycles; it then recaptures on every such edge.
- Prescaler CNT:
  - Counts from 0 to SCAN_DIV-1, incrementing every CLK.
  - When CNT=SCAN_DIV-1, CNT returns to 0 and the digit index IDX advances.
- Digit index IDX:
  - Counts 0,1,2,3,4,5, then wraps to 0.
  - It advances only when CNT wraps.
- Segment decode, applied to D = HOLD digit IDX:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110.
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
  - Codes 10..15 show a dash (1000000).
- Leading-zero blanking, when BLANK_EN=1:
  - Digit k (k in 1..5) is blanked (SEG=0000000) when HOLD digits k..5 are all zero.
  - Digit 0 is never blanked, so a value of 0 displays as a single "0".
  - Invalid codes count as non-zero.
- Dead-time: in the cycle computed from CNT=0, DIG_N=111111 and SEG=0000000.
- Outputs are registered. The values seen after edge n are computed from the CNT, IDX, HOLD and BLANK_EN state present before edge n:
  - DIG_N[k]=0 iff IDX=k and CNT≠0.
  - SEG is the blanked or decoded digit IDX when CNT≠0, and 0 otherwise.
- Boundary conditions:
  - LOAD in the same cycle as an IDX advance: both take effect. The new HOLD is used from the next computed output.
  - LOAD during the dead-time cycle: no special handling.
  - A BLANK_EN change takes effect on the next computed output. No glitch-free requirement applies.
  - RST_N low at any time, including mid-digit: all state and outputs clear immediately, independent of CLK. Scanning restarts at digit 0, CNT=0 after release.

## Timing
- Reset values: HOLD=0, CNT=0, IDX=0, SEG=0000000, DIG_N=111111.
- After RST_N deasserts:
  - Edge 1: DIG_N=111111 (dead-time from CNT=0).
  - Edge 2: DIG_N=111110 and SEG=0111111 ("0").
- Digit period is SCAN_DIV cycles: 1 dead-time cycle plus SCAN_DIV-1 selected cycles. A full frame is 6·SCAN_DIV cycles.
- LOAD-to-display latency: HOLD updates at the LOAD edge. Output reflects the new value at the following edge if the digit is then selected.
- No more than one DIG_N bit is ever low.

## Test plan
- Reset, idle, SCAN_DIV=4:
  - Stimulus: RST_N pulse, no LOAD.
  - Required: SEG=0/DIG_N=111111 during reset.
  - Required: then a repeating 24-cycle frame. Each digit shows 1 cycle of 111111, then 3 cycles of its select code with SEG=0111111.
- LOAD 0x123456 with BLANK_EN=0:
  - Required: digit0 SEG=1111101 ("6"), digit1 1101101, digit2 1100110, digit3 1001111, digit4 1011011, digit5 0000110.
  - Required: DIG_N sequence 111110, 111101, …, 011111.
- LOAD 0x000305 with BLANK_EN=1:
  - Required: digits 3..5 SEG=0000000.
  - Required: digit2 1001111, digit1 0111111 (the inner zero is kept), digit0 1101101.
- LOAD 0x000000 with BLANK_EN=1:
  - Required: only digit0 shows 0111111; the other five are blank.
- LOAD 0x00000A:
  - Required: digit0 SEG=1000000 (dash).
- Simultaneous events and async reset:
  - Stimulus: LOAD asserted on the same edge as an IDX wrap 5→0.
  - Required: the next selected digit0 shows the new value.
  - Stimulus: RST_N asserted mid-digit, between clock edges.
  - Required: outputs clear before the next CLK edge.
